// File: rtl/frame_scheduler.sv
// Frame scheduler: runs map drawer then sprite drawer per frame; fb_* mux is zero-latency, control pulses decode registered state.
// No backpressure: frame_start while busy is dropped with an overrun pulse. Define FRAME_TIMEOUT_EN to add the RUN-state abort watchdog.
module frame_scheduler #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic        map_start,
  input  logic        map_done,
  input  logic        map_we,
  input  logic [16:0] map_addr,
  input  logic [23:0] map_data,
  output logic        spr_start,
  input  logic        spr_done,
  input  logic        spr_we,
  input  logic [16:0] spr_addr,
  input  logic [23:0] spr_data,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [23:0] fb_data,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic        timeout,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_MAP_START, S_MAP_RUN, S_SPR_START, S_SPR_RUN, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_first_run;
  logic        r_overrun;
  logic [7:0]  r_frame_cnt;
  logic        w_run;
  logic        w_run_done;
  logic        w_abort;

  assign w_run = (r_state == S_MAP_RUN) || (r_state == S_SPR_RUN);
  // A drawer's done level is stale in the first RUN cycle, so it only counts afterwards.
  assign w_run_done = !r_first_run &&
                      (((r_state == S_MAP_RUN) && map_done) ||
                       ((r_state == S_SPR_RUN) && spr_done));

`ifdef FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;
  logic          r_timeout;

  assign w_abort = w_run && !w_run_done && (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout = r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == S_MAP_START) || (r_state == S_SPR_START)) begin
        r_to_cnt <= '0;
      end else if (w_run) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if ((r_state == S_IDLE) && frame_start) begin
        r_timeout <= 1'b0;
      end else if (w_abort) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  logic w_unused_timeout_param;
  assign w_unused_timeout_param = (TIMEOUT_CYCLES > 0);
  assign w_abort = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_first_run <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state     <= w_next;
      r_first_run <= (r_state == S_MAP_START) || (r_state == S_SPR_START);
      r_overrun   <= frame_start && (r_state != S_IDLE);
      // An aborted frame still passes through DONE but is not counted.
      if ((r_state == S_DONE) && !timeout) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    map_start  = 1'b0;
    spr_start  = 1'b0;
    frame_done = 1'b0;
    fb_we      = 1'b0;
    fb_addr    = 17'd0;
    fb_data    = 24'd0;
    unique case (r_state)
      S_IDLE: begin
        if (frame_start) w_next = S_MAP_START;
      end
      S_MAP_START: begin
        map_start = 1'b1;
        fb_we     = map_we;
        fb_addr   = map_addr;
        fb_data   = map_data;
        w_next    = S_MAP_RUN;
      end
      S_MAP_RUN: begin
        fb_we   = map_we;
        fb_addr = map_addr;
        fb_data = map_data;
        if (w_run_done)   w_next = S_SPR_START;
        else if (w_abort) w_next = S_DONE;
      end
      S_SPR_START: begin
        spr_start = 1'b1;
        fb_we     = spr_we;
        fb_addr   = spr_addr;
        fb_data   = spr_data;
        w_next    = S_SPR_RUN;
      end
      S_SPR_RUN: begin
        fb_we   = spr_we;
        fb_addr = spr_addr;
        fb_data = spr_data;
        if (w_run_done || w_abort) w_next = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: stimulus queues expected frame_done/overrun/fb events, a negedge monitor checks them.
module tb_frame_scheduler;
  logic        clk = 1'b0;
  logic        rst, frame_start, map_done, map_we, spr_done, spr_we;
  logic [16:0] map_addr, spr_addr, fb_addr;
  logic [23:0] map_data, spr_data, fb_data;
  logic        map_start, spr_start, fb_we, busy, frame_done, overrun, timeout;
  logic [7:0]  frame_cnt;

  frame_scheduler #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .map_start(map_start), .map_done(map_done), .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .spr_start(spr_start), .spr_done(spr_done), .spr_we(spr_we), .spr_addr(spr_addr), .spr_data(spr_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout(timeout), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] cnt; logic to; } done_exp_t;
  typedef struct packed { logic [16:0] addr; logic [23:0] data; } fb_exp_t;

  done_exp_t q_done[$];
  fb_exp_t   q_fb[$];
  int        q_ovr[$];
  done_exp_t mon_d;
  fb_exp_t   mon_f;
  int        mon_o;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_map_start = 0, n_spr_start = 0, exp_map_start = 0, exp_spr_start = 0;
  int last_frame_len = 0;
  logic [7:0] model_cnt = 8'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (map_start) n_map_start++;
      if (spr_start) n_spr_start++;
      if (frame_done) begin
        if (q_done.size() == 0) flag("frame_done", "pulse with nothing expected");
        else begin
          mon_d = q_done.pop_front();
          check("frame_cnt_in_done", frame_cnt, mon_d.cnt);
          check("timeout_in_done", timeout, mon_d.to);
        end
      end
      if (overrun) begin
        if (q_ovr.size() == 0) flag("overrun", "pulse with nothing expected");
        else begin
          mon_o = q_ovr.pop_front();
          check("overrun_cycle", cyc, mon_o);
        end
      end
      if (fb_we) begin
        if (q_fb.size() == 0) flag("fb_we", "write with nothing expected");
        else begin
          mon_f = q_fb.pop_front();
          check("fb_addr", fb_addr, mon_f.addr);
          check("fb_data", fb_data, mon_f.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int sel);
    return (sel == 0) ? spr_start : frame_done;
  endfunction

  task automatic wait_for(input int sel, input int limit, input string name);
    int n = 0;
    while (!cond(sel) && n < limit) begin
      tick();
      n++;
    end
    if (!cond(sel)) flag(name, "no response within cycle bound");
  endtask

  task automatic poke_start();
    frame_start = 1'b1;
    q_ovr.push_back(cyc + 1);
    tick();
    frame_start = 1'b0;
  endtask

  task automatic accept_start();
    frame_start = 1'b1;
    exp_map_start++;
    tick();
    frame_start = 1'b0;
    map_done = 1'b0;
  endtask

  task automatic run_frame(input int map_len, input int spr_len, input bit grant, input bit ovr);
    bit busy_ok = 1'b1;
    int t0;
    q_done.push_back({model_cnt, 1'b0});
    model_cnt = model_cnt + 8'd1;
    exp_spr_start++;
    if (map_len == 0) begin
      frame_start = 1'b1;
      exp_map_start++;
      tick();
      frame_start = 1'b0;
    end else accept_start();
    t0 = cyc;
    for (int i = 0; i < map_len; i++) begin
      tick();
      if (!busy) busy_ok = 1'b0;
      if (ovr && i == map_len / 4) poke_start();
      if (grant && i == map_len / 2) begin
        map_we = 1'b1; map_addr = 17'd76799; map_data = 24'hFF0000;
        spr_we = 1'b1; spr_addr = 17'd5;     spr_data = 24'h00ABCD;
        q_fb.push_back({17'd76799, 24'hFF0000});
        tick();
        map_we = 1'b0; spr_we = 1'b0;
      end
    end
    map_done = 1'b1;
    wait_for(0, 10, "spr_start_wait");
    if (spr_len > 0) spr_done = 1'b0;
    for (int i = 0; i < spr_len; i++) begin
      tick();
      if (!busy) busy_ok = 1'b0;
      if (grant && i == spr_len / 2) begin
        map_we = 1'b1; map_addr = 17'd76799; map_data = 24'hFF0000;
        spr_we = 1'b1; spr_addr = 17'd5;     spr_data = 24'h00ABCD;
        q_fb.push_back({17'd5, 24'h00ABCD});
        tick();
        map_we = 1'b0; spr_we = 1'b0;
      end
    end
    spr_done = 1'b1;
    wait_for(1, 10, "frame_done_wait");
    last_frame_len = cyc - t0;
    if (ovr) poke_start();
    else tick();
    check("busy_during_frame", busy_ok, 1'b1);
    check("idle_after_frame", busy, 1'b0);
    check("frame_cnt_after", frame_cnt, model_cnt);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b1; map_done = 1'b1; spr_done = 1'b1;
    map_we = 1'b0; map_addr = 17'd0; map_data = 24'd0;
    spr_we = 1'b0; spr_addr = 17'd0; spr_data = 24'd0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_frame_cnt", frame_cnt, 8'd0);
    check("rst_map_start", map_start, 1'b0);
    check("rst_spr_start", spr_start, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_fb_we", fb_we, 1'b0);
    frame_start = 1'b0;
    tick();

    // Requesters writing while IDLE must not reach the frame buffer.
    map_we = 1'b1; map_addr = 17'd76799; map_data = 24'hFF0000;
    spr_we = 1'b1; spr_addr = 17'd5;     spr_data = 24'h00ABCD;
    #1;
    check("idle_fb_we", fb_we, 1'b0);
    check("idle_fb_addr", fb_addr, 17'd0);
    check("idle_fb_data", fb_data, 24'd0);
    map_we = 1'b0; spr_we = 1'b0;
    tick();

    run_frame(60, 20, 1'b1, 1'b0);
    run_frame(0, 0, 1'b0, 1'b0);
    check("min_frame_latency", last_frame_len, 6);
    run_frame(40, 10, 1'b0, 1'b1);
    tick();

    // Reset in SPR_RUN with frame_start, spr_done and a sprite write all active.
    accept_start();
    exp_spr_start++;
    repeat (5) tick();
    map_done = 1'b1;
    wait_for(0, 10, "rst_test_spr_start");
    spr_done = 1'b0;
    repeat (3) tick();
    rst = 1'b1; frame_start = 1'b1; spr_done = 1'b1;
    spr_we = 1'b1; spr_addr = 17'd9; spr_data = 24'h123456;
    tick();
    rst = 1'b0; frame_start = 1'b0;
    model_cnt = 8'd0;
    check("midrst_fb_we", fb_we, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_frame_cnt", frame_cnt, 8'd0);
    check("midrst_overrun", overrun, 1'b0);
    check("midrst_frame_done", frame_done, 1'b0);
    spr_we = 1'b0;
    tick();
    run_frame(3, 2, 1'b0, 1'b0);

`ifdef FRAME_TIMEOUT_EN
    begin
      int n = 0;
      q_done.push_back({model_cnt, 1'b1});
      accept_start();
      while (!frame_done && n < 300) begin
        tick();
        n++;
      end
      check("abort_latency", n, 101);
      check("abort_timeout", timeout, 1'b1);
      tick();
      check("abort_frame_cnt", frame_cnt, model_cnt);
      check("abort_timeout_sticky", timeout, 1'b1);
      map_done = 1'b1;
      run_frame(5, 5, 1'b0, 1'b0);
      check("timeout_cleared", timeout, 1'b0);
    end
`else
    begin
      int n_fd = 0;
      accept_start();
      repeat (150) begin
        tick();
        if (frame_done) n_fd++;
      end
      check("stuck_no_frame_done", n_fd, 0);
      check("stuck_busy", busy, 1'b1);
      check("stuck_timeout", timeout, 1'b0);
    end
`endif

    rst = 1'b1;
    tick();
    rst = 1'b0;
    map_done = 1'b1;
    model_cnt = 8'd0;
    tick();
    for (int f = 0; f < 256; f++) run_frame(1, 1, 1'b0, 1'b0);
    check("frame_cnt_wrap", frame_cnt, 8'd0);

    repeat (3) tick();
    check("done_queue_empty", q_done.size(), 0);
    check("ovr_queue_empty", q_ovr.size(), 0);
    check("fb_queue_empty", q_fb.size(), 0);
    check("map_start_cycles", n_map_start, exp_map_start);
    check("spr_start_cycles", n_spr_start, exp_spr_start);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
